// File: rtl/pig_force_gen_pkg.sv
// pig_pkg: shared types, widths and saturation helpers for pig_force_gen.
//   FX_W/FRAC_W  force format (17-bit signed, 6 fractional bits)
//   CNT_W        overlap counter width, CRN_W corner counter width
//   pig_state_e  ACCUM -> CALC1 -> CALC2 -> HOLD
package pig_pkg;
  localparam int FX_W   = 17;
  localparam int FRAC_W = 6;
  localparam int CNT_W  = 11;
  localparam int CRN_W  = 10;
  localparam int DIFF_W = 12;  // registered dx/dy
  localparam int DACC_W = 14;  // headroom for diff + corner halves
  localparam int SH_W   = 20;  // headroom for diff <<< GAIN_SHIFT

  // overlap counter slots
  localparam int CR = 0;
  localparam int CL = 1;
  localparam int CD = 2;
  localparam int CU = 3;

  typedef enum logic [1:0] {ACCUM, CALC1, CALC2, HOLD} pig_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic signed [DACC_W-1:0] ext_cnt(input logic [CNT_W-1:0] c);
    return $signed({{(DACC_W-CNT_W){1'b0}}, c});
  endfunction

  function automatic logic signed [DACC_W-1:0] half_crn(input logic [CRN_W-1:0] c);
    return $signed({{(DACC_W-CRN_W+1){1'b0}}, c[CRN_W-1:1]});
  endfunction

  // clamp to the 12-bit signed diff range
  function automatic logic signed [DIFF_W-1:0] sat_diff(input logic signed [DACC_W-1:0] v);
    if (v > 14'sd2047)       return 12'sd2047;
    else if (v < -14'sd2048) return -12'sd2048;
    else                     return v[DIFF_W-1:0];
  endfunction

  // symmetric clamp to [-max, +max]
  function automatic logic signed [FX_W-1:0] clamp_force(input logic signed [SH_W-1:0] v,
                                                         input logic [FX_W-1:0] max);
    logic signed [SH_W-1:0] m;
    m = $signed({{(SH_W-FX_W){1'b0}}, max});
    if (v > m)       return $signed(max);
    else if (v < -m) return -$signed(max);
    else             return v[FX_W-1:0];
  endfunction
endpackage

// File: rtl/pig_force_gen_if.sv
// pig_force_gen_if: scan/collision inputs and force outputs of pig_force_gen.
//   master: video/collision side (drives scan + pig_dir, samples forces)
//   slave : pig_force_gen
interface pig_force_gen_if;
  logic                             vsync;
  logic [9:0]                       h_cnt;
  logic [9:0]                       v_cnt;
  logic                             pig;
  logic                             obj;
  logic [3:0]                       pig_dir;  // {x-band, y-band, right, below}
  logic signed [pig_pkg::FX_W-1:0]  pig_force_x;
  logic signed [pig_pkg::FX_W-1:0]  pig_force_y;
  logic                             contact;
  logic                             force_valid;

  modport master (
    output vsync, h_cnt, v_cnt, pig, obj, pig_dir,
    input  pig_force_x, pig_force_y, contact, force_valid
  );
  modport slave (
    input  vsync, h_cnt, v_cnt, pig, obj, pig_dir,
    output pig_force_x, pig_force_y, contact, force_valid
  );
endinterface

// File: rtl/pig_force_gen_force_sat.sv
// force_sat: one axis of force conversion.
//   diff_i  12-bit signed overlap difference
//   force_o diff <<< GAIN_SHIFT, clamped to [-MAX_FORCE, +MAX_FORCE]
module force_sat import pig_pkg::*; #(
  parameter logic [2:0]      GAIN_SHIFT = 3'd2,
  parameter logic [FX_W-1:0] MAX_FORCE  = 17'd2048
) (
  input  logic signed [DIFF_W-1:0] diff_i,
  output logic signed [FX_W-1:0]   force_o
);
  logic signed [SH_W-1:0] ext, shifted;

  // widen first so no shift amount can wrap before the clamp
  assign ext     = {{(SH_W-DIFF_W){diff_i[DIFF_W-1]}}, diff_i};
  assign shifted = ext <<< GAIN_SHIFT;
  assign force_o = clamp_force(shifted, MAX_FORCE);
endmodule

// File: rtl/pig_force_gen.sv
// pig_force_gen: per-frame collision impulse for one pig object.
//   clk, rst_n  clock, async active-low reset
//   bus (slave) scan position, pig/obj masks, pig_dir in; forces, contact,
//               force_valid out
// Accumulates directional overlap counts during the active scan, converts them
// to clamped fixed-point forces in blanking and holds them until vsync.
// Build option: PIG_FORCE_DIAG_EN adds per-quadrant corner counters whose halves
// feed both axes; without it corner overlaps only set contact.
module pig_force_gen import pig_pkg::*; #(
  parameter logic [9:0]      D_WIDTH    = 10'd640,
  parameter logic [9:0]      D_HEIGHT   = 10'd480,
  parameter logic [2:0]      GAIN_SHIFT = 3'd2,
  parameter logic [FX_W-1:0] MAX_FORCE  = FX_W'(32 << FRAC_W),
  parameter bit              IMPULSE    = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  pig_force_gen_if.slave  bus
);
  pig_state_e               state_q, state_d;
  logic [3:0][CNT_W-1:0]    cnt_q;
  logic                     ov_seen_q;
  logic signed [DIFF_W-1:0] dx_q, dy_q;
  logic signed [FX_W-1:0]   fx_q, fy_q, fx_w, fy_w;
  logic                     contact_q, fvld_q;
  logic signed [DACC_W-1:0] dx_w, dy_w;
  logic                     ov, frame_end, clr;

  assign ov        = bus.pig & bus.obj & (bus.h_cnt < D_WIDTH) & (bus.v_cnt < D_HEIGHT);
  assign frame_end = (bus.h_cnt == '0) && (bus.v_cnt == D_HEIGHT);
  assign clr       = (state_q == HOLD) && bus.vsync;

`ifdef PIG_FORCE_DIAG_EN
  // corner quadrant index = {right, below}: 0 UL, 1 DL, 2 UR, 3 DR
  logic [3:0][CRN_W-1:0] crn_q;
  logic                  crn;
  logic [1:0]            qd;

  assign crn = ov & ~bus.pig_dir[3] & ~bus.pig_dir[2];
  assign qd  = bus.pig_dir[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        crn_q     <= '0;
    else if (clr)                                      crn_q     <= '0;
    else if (state_q == ACCUM && crn && crn_q[qd] != '1) crn_q[qd] <= crn_q[qd] + CRN_W'(1);
  end

  // a corner on the left/top pushes towards +x/+y, like the edge counters
  always_comb begin
    dx_w = ext_cnt(cnt_q[CL]) - ext_cnt(cnt_q[CR])
         + half_crn(crn_q[0]) + half_crn(crn_q[1])
         - half_crn(crn_q[2]) - half_crn(crn_q[3]);
    dy_w = ext_cnt(cnt_q[CU]) - ext_cnt(cnt_q[CD])
         + half_crn(crn_q[0]) + half_crn(crn_q[2])
         - half_crn(crn_q[1]) - half_crn(crn_q[3]);
  end
`else
  always_comb begin
    dx_w = ext_cnt(cnt_q[CL]) - ext_cnt(cnt_q[CR]);
    dy_w = ext_cnt(cnt_q[CU]) - ext_cnt(cnt_q[CD]);
  end
`endif

  force_sat #(.GAIN_SHIFT(GAIN_SHIFT), .MAX_FORCE(MAX_FORCE)) u_sat_x (
    .diff_i (dx_q),
    .force_o(fx_w)
  );
  force_sat #(.GAIN_SHIFT(GAIN_SHIFT), .MAX_FORCE(MAX_FORCE)) u_sat_y (
    .diff_i (dy_q),
    .force_o(fy_w)
  );

  // entering CALC1 is the registered frame_end; frame_end outside ACCUM is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (frame_end) state_d = CALC1;
      CALC1:   state_d = CALC2;
      CALC2:   state_d = HOLD;
      HOLD:    if (bus.vsync) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      ov_seen_q <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      fx_q      <= '0;
      fy_q      <= '0;
      contact_q <= 1'b0;
      fvld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ACCUM: if (ov) begin
          // ov_seen covers corner pixels too, so contact needs no corner counters
          ov_seen_q <= 1'b1;
          if (bus.pig_dir[2]) begin
            if (bus.pig_dir[1]) cnt_q[CR] <= sat_inc(cnt_q[CR]);
            else                cnt_q[CL] <= sat_inc(cnt_q[CL]);
          end
          if (bus.pig_dir[3]) begin
            if (bus.pig_dir[0]) cnt_q[CD] <= sat_inc(cnt_q[CD]);
            else                cnt_q[CU] <= sat_inc(cnt_q[CU]);
          end
        end
        CALC1: begin
          dx_q <= sat_diff(dx_w);
          dy_q <= sat_diff(dy_w);
        end
        CALC2: begin
          fx_q      <= fx_w;
          fy_q      <= fy_w;
          contact_q <= ov_seen_q;
          fvld_q    <= 1'b1;
        end
        HOLD: if (bus.vsync) begin
          // the pig samples on this edge; outputs change only after it
          cnt_q     <= '0;
          ov_seen_q <= 1'b0;
          fvld_q    <= 1'b0;
          if (IMPULSE) begin
            fx_q <= '0;
            fy_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pig_force_x = fx_q;
  assign bus.pig_force_y = fy_q;
  assign bus.contact     = contact_q;
  assign bus.force_valid = fvld_q;
endmodule
